// File: rtl/priority_decoder_stream.sv
// priority_decoder_stream: encoded index to one-hot vector behind a valid/ready register stage.
// Define PRIORITY_DECODER_SKID_EN for a two-entry skid buffer with a registered in_ready.
module priority_decoder_stream #(
  parameter int WIDTH = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_LOG-1:0] enc_idx,
  input  logic                 enc_vld,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dec_vld,
  output logic                 dec_err
);
  logic             in_range;
  logic [WIDTH-1:0] dec_d;
  logic             err_d;
  logic             in_xfer;
  logic             out_xfer;
  // Widened compare so indices past a non-power-of-2 WIDTH are caught.
  assign in_range = {1'b0, enc_idx} < (WIDTH_LOG+1)'(WIDTH);
  assign dec_d    = (enc_vld && in_range) ? WIDTH'(1) << enc_idx : '0;
  assign err_d    = enc_vld && !in_range;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
`ifdef PRIORITY_DECODER_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_vld_q, skid_vld_q;
  logic             main_err_q, skid_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != TWO;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   state_d = in_xfer ? ONE : EMPTY;
      ONE:     state_d = (in_xfer && !out_xfer) ? TWO : (out_xfer && !in_xfer) ? EMPTY : ONE;
      TWO:     state_d = out_xfer ? ONE : TWO;
      default: state_d = EMPTY;
    endcase
  end
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = state_q != EMPTY;
    dec_vld   = main_vld_q;
    dec_err   = main_err_q;
  end
  // Main always holds the oldest beat; skid only fills when main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= '0;
      main_err_q <= 1'b0;
      skid_vld_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (state_q == TWO && out_xfer) begin
        main_vld_q <= skid_vld_q;
        main_err_q <= skid_err_q;
      end else if (in_xfer && (state_q == EMPTY || out_xfer)) begin
        main_vld_q <= dec_d;
        main_err_q <= err_d;
      end
      if (in_xfer && state_q == ONE && !out_xfer) begin
        skid_vld_q <= dec_d;
        skid_err_q <= err_d;
      end
    end
  end
`else
  logic             valid_q;
  logic             err_q;
  logic [WIDTH-1:0] vld_q;
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign dec_vld   = vld_q;
  assign dec_err   = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      vld_q   <= '0;
      err_q   <= 1'b0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      vld_q   <= dec_d;
      err_q   <= err_d;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_priority_decoder_stream.sv
// tb_priority_decoder_stream: scoreboard bench for a WIDTH=32 and a WIDTH=5 instance.
module tb_priority_decoder_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        in_valid32 = 1'b0, in_ready32, enc_vld32 = 1'b0, out_valid32, out_ready32 = 1'b1, dec_err32;
  logic [4:0]  enc_idx32 = '0;
  logic [31:0] dec_vld32;
  logic        in_valid5 = 1'b0, in_ready5, enc_vld5 = 1'b0, out_valid5, out_ready5 = 1'b1, dec_err5;
  logic [2:0]  enc_idx5 = '0;
  logic [4:0]  dec_vld5;
  int checks = 0;
  int passed = 0;
`ifdef PRIORITY_DECODER_SKID_EN
  localparam int STALL_ACCEPTS = 2;
`else
  localparam int STALL_ACCEPTS = 1;
`endif
  typedef struct packed {logic err; logic [31:0] vld;} beat_t;
  beat_t q32[$], q5[$];
  bit    a32, f32, s32, v32, a5, f5, s5, v5;
  beat_t e32, g32, e5, g5;

  priority_decoder_stream #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .enc_idx(enc_idx32),
    .enc_vld(enc_vld32), .out_valid(out_valid32), .out_ready(out_ready32), .dec_vld(dec_vld32), .dec_err(dec_err32));
  priority_decoder_stream #(.WIDTH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5), .enc_idx(enc_idx5),
    .enc_vld(enc_vld5), .out_valid(out_valid5), .out_ready(out_ready5), .dec_vld(dec_vld5), .dec_err(dec_err5));

  function automatic beat_t model(int idx, logic v, int w);
    beat_t b;
    b.err = v && idx >= w;
    b.vld = '0;
    if (v && idx < w) b.vld[idx] = 1'b1;
    return b;
  endfunction

  // One clock: sample handshakes mid-cycle, pop expected on output beats, push on accepted inputs.
  task automatic cycle();
    @(negedge clk);
    a32 = in_valid32 && in_ready32;
    f32 = out_valid32 && out_ready32;
    s32 = out_valid32 && !out_ready32;
    v32 = out_valid32;
    g32 = {dec_err32, dec_vld32};
    e32 = 'x;
    if (f32 && q32.size() > 0) e32 = q32.pop_front();
    if (a32) q32.push_back(model(int'(enc_idx32), enc_vld32, 32));
    a5 = in_valid5 && in_ready5;
    f5 = out_valid5 && out_ready5;
    s5 = out_valid5 && !out_ready5;
    v5 = out_valid5;
    g5 = {dec_err5, 27'd0, dec_vld5};
    e5 = 'x;
    if (f5 && q5.size() > 0) e5 = q5.pop_front();
    if (a5) q5.push_back(model(int'(enc_idx5), enc_vld5, 5));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid32, dec_err32, dec_vld32} !== '0) $display("FAIL reset_out32 got v=%b e=%b d=%h want all 0", out_valid32, dec_err32, dec_vld32);
    else passed++;
    checks++;
    if ({out_valid5, dec_err5, dec_vld5} !== '0) $display("FAIL reset_out5 got v=%b e=%b d=%h want all 0", out_valid5, dec_err5, dec_vld5);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready32, in_ready5} !== 2'b11) $display("FAIL reset_in_ready got %b%b want 11", in_ready32, in_ready5);
    else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready32 = 1'b1;
    enc_vld32 = 1'b1;
    for (int k = 0; k < 33; k++) begin
      in_valid32 = k < 32;
      enc_idx32 = 5'(k);
      cycle();
      if (k < 32) begin
        checks++;
        if (!a32) $display("FAIL b2b_accept k=%0d got in_ready=0 want 1", k);
        else passed++;
      end
      checks++;
      if (v32 !== (k > 0)) $display("FAIL b2b_latency k=%0d got out_valid=%b want %b", k, v32, k > 0);
      else passed++;
      if (k > 0) begin
        checks++;
        if (g32 !== e32 || g32.vld !== 32'd1 << (k - 1)) $display("FAIL b2b_data k=%0d got %h want %h", k - 1, g32, e32);
        else passed++;
      end
    end
    in_valid32 = 1'b0;
  endtask

  task automatic test_enc_vld_zero();
    out_ready32 = 1'b1;
    enc_vld32 = 1'b0;
    enc_idx32 = 5'd5;
    in_valid32 = 1'b1;
    cycle();
    in_valid32 = 1'b0;
    cycle();
    checks++;
    if (!f32 || g32 !== e32 || g32 !== '0) $display("FAIL enc_vld_zero got valid=%b %h want valid=1 %h", f32, g32, beat_t'(0));
    else passed++;
  endtask

  task automatic test_nonpow2();
    int    idx[6] = '{6, 4, 0, 7, 5, 6};
    logic  vl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    out_ready5 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid5 = k < 6;
      enc_idx5 = 3'(idx[k < 6 ? k : 5]);
      enc_vld5 = vl[k < 6 ? k : 5];
      cycle();
      if (k > 0) begin
        checks++;
        if (!f5 || g5 !== e5) $display("FAIL nonpow2 idx=%0d got valid=%b %h want %h", idx[k - 1], f5, g5, e5);
        else passed++;
      end
      if (k == 1) begin
        checks++;
        if (g5 !== {1'b1, 32'd0}) $display("FAIL nonpow2_err6 got %h want %h", g5, {1'b1, 32'd0});
        else passed++;
      end
    end
    in_valid5 = 1'b0;
  endtask

  task automatic test_skid();
    int idxs[3] = '{3, 7, 9};
    int n = 0;
    int m = 0;
    out_ready32 = 1'b0;
    enc_vld32 = 1'b1;
    in_valid32 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      enc_idx32 = 5'(idxs[n]);
      cycle();
      if (a32) n++;
    end
    checks++;
    if (n != STALL_ACCEPTS) $display("FAIL skid_accepts got %0d want %0d", n, STALL_ACCEPTS);
    else passed++;
    checks++;
    if (in_ready32 !== 1'b0) $display("FAIL skid_in_ready got %b want 0", in_ready32);
    else passed++;
    out_ready32 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid32 = n < 3;
      enc_idx32 = 5'(idxs[n < 3 ? n : 2]);
      cycle();
      if (a32) n++;
      if (f32) begin
        checks++;
        if (m > 2 || g32 !== e32 || g32.vld !== 32'd1 << idxs[m]) $display("FAIL skid_order beat=%0d got %h want %h", m, g32, e32);
        else passed++;
        m++;
      end
    end
    in_valid32 = 1'b0;
    checks++;
    if (m != 3) $display("FAIL skid_count got %0d want 3", m);
    else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready32 = 1'b0;
    in_valid32 = 1'b1;
    enc_vld32 = 1'b1;
    enc_idx32 = 5'd12;
    cycle();
    enc_idx32 = 5'd13;
    cycle();
    cycle();
    in_valid32 = 1'b0;
    checks++;
    if (out_valid32 !== 1'b1) $display("FAIL midrst_pre got out_valid=%b want 1", out_valid32);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid32, dec_err32, dec_vld32} !== '0) $display("FAIL midrst_async got v=%b e=%b d=%h want all 0", out_valid32, dec_err32, dec_vld32);
    else passed++;
    q32.delete();
    q5.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready32, out_valid32} !== 2'b10) $display("FAIL midrst_release got in_ready=%b out_valid=%b want 1 0", in_ready32, out_valid32);
    else passed++;
    out_ready32 = 1'b1;
  endtask

  task automatic test_random();
    int    acc = 0;
    int    cyc = 0;
    bit    h32 = 0, h5 = 0;
    beat_t p32 = '0, p5 = '0;
    while ((acc < 10000 || q32.size() > 0) && cyc < 40000) begin
      in_valid32  = acc < 10000 && $urandom_range(0, 3) != 0;
      enc_vld32   = $urandom_range(0, 7) != 0;
      enc_idx32   = 5'($urandom);
      out_ready32 = $urandom_range(0, 3) != 0;
      in_valid5   = $urandom_range(0, 1) != 0;
      enc_vld5    = $urandom_range(0, 7) != 0;
      enc_idx5    = 3'($urandom);
      out_ready5  = $urandom_range(0, 2) != 0;
      cycle();
      cyc++;
      if (a32) acc++;
      if (f32) begin
        checks++;
        if (g32 !== e32 || $countones(g32.vld) > 1) $display("FAIL rand32 cyc=%0d got %h want %h", cyc, g32, e32);
        else passed++;
      end
      if (f5) begin
        checks++;
        if (g5 !== e5 || $countones(g5.vld) > 1) $display("FAIL rand5 cyc=%0d got %h want %h", cyc, g5, e5);
        else passed++;
      end
      if (h32) begin
        checks++;
        if (!v32 || g32 !== p32) $display("FAIL hold32 cyc=%0d got v=%b %h want v=1 %h", cyc, v32, g32, p32);
        else passed++;
      end
      if (h5) begin
        checks++;
        if (!v5 || g5 !== p5) $display("FAIL hold5 cyc=%0d got v=%b %h want v=1 %h", cyc, v5, g5, p5);
        else passed++;
      end
      h32 = s32;
      p32 = g32;
      h5 = s5;
      p5 = g5;
    end
    in_valid32 = 1'b0;
    in_valid5 = 1'b0;
    out_ready5 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (f5) begin
        checks++;
        if (g5 !== e5) $display("FAIL rand5_drain got %h want %h", g5, e5);
        else passed++;
      end
    end
    checks++;
    if (acc < 10000 || q32.size() != 0 || q5.size() != 0) $display("FAIL rand_complete got acc=%0d q32=%0d q5=%0d want 10000 0 0", acc, q32.size(), q5.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_enc_vld_zero();
    test_nonpow2();
    test_skid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached passed=%0d checks=%0d", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/priority_decoder_stream.md
PRIORITY_DECODER_STREAM -- requirements
Module: priority_decoder_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the number of decoded one-hot bits; legal range 2..1024.
REQ-002 The block SHALL have localparam WIDTH_LOG = $clog2(WIDTH), giving the index width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, indicating the input beat is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, indicating the block accepts the input beat.
REQ-007 The block SHALL have port enc_idx, input, WIDTH_LOG bits, the encoded index.
REQ-008 The block SHALL have port enc_vld, input, 1 bit; 0 means "no bit set", matching encoder semantics.
REQ-009 The block SHALL have port out_valid, output, 1 bit, indicating the output beat is present.
REQ-010 The block SHALL have port out_ready, input, 1 bit, indicating downstream accepts the beat.
REQ-011 The block SHALL have port dec_vld, output, WIDTH bits, the one-hot (or all-zero) decoded vector.
REQ-012 The block SHALL have port dec_err, output, 1 bit, flagging an out-of-range index.

Function
REQ-013 The block SHALL perform an input transfer when in_valid && in_ready, and an output transfer when out_valid && out_ready.
REQ-014 The block SHALL set per beat: dec_vld[i]=1 iff enc_vld && enc_idx==i && enc_idx<WIDTH; all other bits 0.
REQ-015 The block SHALL set per beat: dec_err=1 iff enc_vld && enc_idx>=WIDTH (reachable only for non-power-of-2 WIDTH); dec_vld is then all-zero.
REQ-016 The block SHALL set per beat: enc_vld=0 yields dec_vld all-zero and dec_err=0, independent of enc_idx.
REQ-017 The block SHALL keep dec_vld at popcount <= 1 on every output beat.
REQ-018 The block SHALL have a latency of exactly 1 cycle: beat accepted in cycle N gives out_valid=1 in cycle N+1 if storage ahead of it is empty.
REQ-019 The block SHALL deliver beats in acceptance order with no loss and no duplication.
REQ-020 The block SHALL hold dec_vld and dec_err stable while out_valid && !out_ready.
REQ-021 The block SHALL sustain one beat per cycle throughput when out_ready is held 1.
REQ-022 The block SHALL let out_valid depend only on registered state, with no combinational in_valid to out_valid path.

Reset
REQ-023 While rst_n=0, the block SHALL hold out_valid=0, dec_vld=0, dec_err=0, all storage empty.
REQ-024 The block SHALL drive in_ready=1 on the first clock after rst_n deasserts.
REQ-025 Reset asserted mid-stream SHALL discard all stored beats immediately, asynchronously.

Configuration
REQ-026 The block SHALL use macro PRIORITY_DECODER_SKID_EN to select the storage structure.
REQ-027 With PRIORITY_DECODER_SKID_EN defined, the block SHALL use two entries (main, skid) with states EMPTY, ONE, TWO.
REQ-028 With the macro defined, in_ready SHALL be a register output equal to (state != TWO), with no out_ready to in_ready path.
REQ-029 With the macro defined, transitions SHALL be: EMPTY to ONE on in-transfer; ONE to TWO on in-transfer without out-transfer; ONE to EMPTY on out-transfer without in-transfer; TWO to ONE on out-transfer, skid moving to main; all other cases keep the state.
REQ-030 Without the macro, the block SHALL use one entry with in_ready = !out_valid || out_ready (combinational).
REQ-031 Both variants SHALL be functionally identical at the beat level.

Verification
REQ-032 The bench SHALL cover: WIDTH=32, out_ready=1, enc_idx=0..31 with enc_vld=1 back-to-back -> dec_vld=1<<k one cycle later, 32 beats in 32 cycles.
REQ-033 The bench SHALL cover: enc_vld=0, enc_idx=5 -> dec_vld=0, dec_err=0, out_valid=1.
REQ-034 The bench SHALL cover: WIDTH=5, enc_idx=6, enc_vld=1 -> dec_vld=5'b00000, dec_err=1.
REQ-035 The bench SHALL cover: skid variant, out_ready=0, indices 3,7,9 offered -> 3 and 7 accepted, in_ready=0 thereafter; out_ready=1 -> outputs 1<<3, 1<<7, 1<<9 in order.
REQ-036 The bench SHALL cover: rst_n pulsed low with state TWO -> out_valid=0 and dec_vld=0 at once; in_ready=1 the first clock after release.
REQ-037 The bench SHALL cover: random valid/ready over 10000 beats on both variants -> scoreboard match, popcount(dec_vld) <= 1 on every output beat.
